// File: rtl/byte_chk_appender.sv
// Streams payload bytes straight through and appends a 16-bit ones'-complement
// checksum (big-endian word sum with end-around carry) after each frame.
module byte_chk_appender #(
    parameter bit INVERT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic [15:0] chk_sum,
    output logic        chk_done
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SUM_W  = 16;

    typedef enum logic [1:0] {
        PAYLOAD = 2'd0,
        CHK_HI  = 2'd1,
        CHK_LO  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [SUM_W-1:0]    acc, acc_nxt;
    logic [DATA_W-1:0]   hi, hi_nxt;
    logic                phase, phase_nxt;
    logic [SUM_W-1:0]    sum_nxt;
    logic                done_nxt;
    logic [SUM_W-1:0]    chk;
    logic                accept;

    // Ones'-complement add: a 17-bit sum with its carry wrapped back in.
    function automatic logic [SUM_W-1:0] fold_add(input logic [SUM_W-1:0] a,
                                                  input logic [SUM_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SUM_W-1:0] + SUM_W'(s[SUM_W]);
    endfunction

    assign chk = INVERT ? ~acc : acc;

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= PAYLOAD;
            acc      <= '0;
            hi       <= '0;
            phase    <= 1'b0;
            chk_sum  <= '0;
            chk_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            hi       <= hi_nxt;
            phase    <= phase_nxt;
            chk_sum  <= sum_nxt;
            chk_done <= done_nxt;
        end
    end

    // Next-state, accumulator update and handshake outputs
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        hi_nxt    = hi;
        phase_nxt = phase;
        sum_nxt   = chk_sum;
        done_nxt  = 1'b0;
        s_ready   = m_ready;
        m_valid   = s_valid;
        m_data    = s_data;
        m_last    = 1'b0;

        // Reset forces the pass-through view regardless of the held state.
        if (rst_n && state == CHK_HI) begin
            s_ready = 1'b0;
            m_valid = 1'b1;
            m_data  = chk[15:8];
        end else if (rst_n && state == CHK_LO) begin
            s_ready = 1'b0;
            m_valid = 1'b1;
            m_data  = chk[7:0];
            m_last  = 1'b1;
        end

        accept = s_valid && s_ready;

        case (state)
            PAYLOAD: begin
                if (accept) begin
                    if (s_last) begin
                        acc_nxt   = phase ? fold_add(acc, {hi, s_data})
                                          : fold_add(acc, {s_data, 8'h00});
                        phase_nxt = 1'b0;
                        state_nxt = CHK_HI;
                    end else if (phase) begin
                        acc_nxt   = fold_add(acc, {hi, s_data});
                        phase_nxt = 1'b0;
                    end else begin
                        hi_nxt    = s_data;
                        phase_nxt = 1'b1;
                    end
                end
            end
            CHK_HI: begin
                if (m_ready) state_nxt = CHK_LO;
            end
            CHK_LO: begin
                if (m_ready) begin
                    state_nxt = PAYLOAD;
                    acc_nxt   = '0;
                    phase_nxt = 1'b0;
                    sum_nxt   = chk;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = PAYLOAD;
        endcase
    end

endmodule

// File: tb/tb_byte_chk_appender.sv
// Randomised bench: an expected output-byte queue built from whole-frame word
// sums is checked against two appenders (inverted and raw) every cycle.
module tb_byte_chk_appender;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [7:0]  data;
        logic [7:0]  raw_data;
        logic        last;
        logic        is_chk;
        logic [15:0] sum;
        logic [15:0] raw_sum;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b1;
    logic        s_ready, m_valid, m_last, chk_done;
    logic [7:0]  m_data;
    logic [15:0] chk_sum;
    logic        r_s_ready, r_m_valid, r_m_last, r_chk_done;
    logic [7:0]  r_m_data;
    logic [15:0] r_chk_sum;

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          frames_exp = 0;
    bit          stall = 1'b0;
    exp_t        expq[$];
    logic        exp_done = 1'b0;
    logic [15:0] exp_sum = 16'h0;
    logic [15:0] exp_raw = 16'h0;

    byte_chk_appender #(.INVERT(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .chk_sum(chk_sum), .chk_done(chk_done)
    );

    byte_chk_appender #(.INVERT(1'b0)) u_raw (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(r_s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(r_m_valid), .m_ready(m_ready),
        .m_data(r_m_data), .m_last(r_m_last), .chk_sum(r_chk_sum), .chk_done(r_chk_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: big-endian 16-bit word sum, odd tail padded with zero, carries wrapped.
    function automatic logic [15:0] model_sum(input bq_t f, input bit inv);
        int unsigned s = 0;
        for (int i = 0; i < f.size(); i += 2) begin
            s += {f[i], (i + 1 < f.size()) ? f[i+1] : 8'h00};
            while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        end
        return inv ? ~s[15:0] : s[15:0];
    endfunction

    // Per-cycle comparison of both instances against the expected queue.
    always @(negedge clk) begin
        logic nd;
        exp_t e;
        check("chk_done", chk_done, exp_done);
        check("raw_chk_done", r_chk_done, exp_done);
        check("chk_sum", chk_sum, exp_sum);
        check("raw_chk_sum", r_chk_sum, exp_raw);
        if (chk_done) done_cnt++;
        nd = 1'b0;
        if (!rst_n || expq.size() == 0 || !expq[0].is_chk) begin
            check("pt_s_ready", s_ready, m_ready);
            check("pt_m_valid", m_valid, s_valid);
            check("pt_m_last", m_last, 1'b0);
            check("raw_pt_s_ready", r_s_ready, m_ready);
            check("raw_pt_m_valid", r_m_valid, s_valid);
            if (s_valid) begin
                check("pt_m_data", m_data, s_data);
                check("raw_pt_m_data", r_m_data, s_data);
            end
            if (!rst_n) begin
                expq.delete();
                exp_sum = 16'h0;
                exp_raw = 16'h0;
            end else if (s_valid && m_ready) begin
                check("byte_expected", 32'(expq.size() != 0), 1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    check("payload_byte", m_data, e.data);
                end
            end
        end else begin
            e = expq[0];
            check("chk_m_valid", m_valid, 1'b1);
            check("chk_s_ready", s_ready, 1'b0);
            check("chk_m_data", m_data, e.data);
            check("chk_m_last", m_last, e.last);
            check("raw_chk_m_data", r_m_data, e.raw_data);
            check("raw_chk_m_last", r_m_last, e.last);
            if (m_ready) begin
                void'(expq.pop_front());
                if (e.last) begin
                    nd = 1'b1;
                    exp_sum = e.sum;
                    exp_raw = e.raw_sum;
                end
            end
        end
        exp_done = nd;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = stall ? ($urandom % 3 != 0) : 1'b1;
        end
    end

    // Queues the expected output for frame f, then offers its first n_send bytes.
    task automatic send_frame(input bq_t f, input int n_send);
        logic [15:0] c, r;
        bit acc;
        c = model_sum(f, 1'b1);
        r = model_sum(f, 1'b0);
        foreach (f[i]) expq.push_back('{f[i], f[i], 1'b0, 1'b0, 16'h0, 16'h0});
        expq.push_back('{c[15:8], r[15:8], 1'b0, 1'b1, 16'h0, 16'h0});
        expq.push_back('{c[7:0], r[7:0], 1'b1, 1'b1, c, r});
        if (n_send == f.size()) frames_exp++;
        for (int i = 0; i < n_send; i++) begin
            acc = 1'b0;
            for (int t = 0; t < 500 && !acc; t++) begin
                s_data  = f[i];
                s_last  = (i == f.size() - 1);
                s_valid = stall ? ($urandom % 4 != 0) : 1'b1;
                @(negedge clk);
                acc = s_valid && s_ready;
                @(posedge clk);
                #1;
            end
            check("accept_timeout", 32'(acc), 1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && expq.size() != 0; i++) @(posedge clk);
        check("drain_timeout", expq.size(), 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bq_t f;
        int d0;
        check("model_basic", model_sum('{8'h45, 8'h00, 8'h00, 8'h1C}, 1'b1), 16'hBAE3);
        check("model_odd", model_sum('{8'h01, 8'h02, 8'h03}, 1'b1), 16'hFBFD);
        check("model_carry_inv", model_sum('{8'hFF, 8'hFF, 8'h00, 8'h01}, 1'b1), 16'hFFFE);
        check("model_carry_raw", model_sum('{8'hFF, 8'hFF, 8'h00, 8'h01}, 1'b0), 16'h0001);

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        send_frame('{8'h45, 8'h00, 8'h00, 8'h1C}, 4);
        drain();
        check("lit_basic", chk_sum, 16'hBAE3);

        send_frame('{8'h01, 8'h02, 8'h03}, 3);
        drain();
        check("lit_odd", chk_sum, 16'hFBFD);

        send_frame('{8'hFF, 8'hFF, 8'h00, 8'h01}, 4);
        drain();
        check("lit_carry_inv", chk_sum, 16'hFFFE);
        check("lit_carry_raw", r_chk_sum, 16'h0001);

        f = {};
        for (int i = 0; i < 9; i++) f.push_back(8'($urandom));
        send_frame(f, 9);
        drain();
        stall = 1'b1;
        send_frame(f, 9);
        drain();
        check("stall_sum", chk_sum, model_sum(f, 1'b1));
        stall = 1'b0;

        // Abandon a frame after 3 bytes; a last-flagged byte during reset must not count.
        d0 = done_cnt;
        send_frame('{8'h12, 8'h34, 8'h56, 8'h78}, 3);
        s_valid = 1'b1;
        s_data  = 8'hAA;
        s_last  = 1'b1;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        send_frame('{8'h45, 8'h00, 8'h00, 8'h1C}, 4);
        drain();
        check("lit_after_abort", chk_sum, 16'hBAE3);
        check("abort_done_cnt", done_cnt - d0, 1);

        send_frame('{8'h01, 8'h02}, 2);
        send_frame('{8'h03}, 1);
        drain();
        check("lit_b2b_second", chk_sum, 16'hFCFF);

        for (int n = 0; n < 20; n++) begin
            f = {};
            for (int i = 0; i < $urandom_range(1, 12); i++) f.push_back(8'($urandom));
            stall = ($urandom % 2 == 1);
            send_frame(f, f.size());
            if ($urandom % 2 == 1) drain();
        end
        stall = 1'b0;
        drain();
        check("done_count", done_cnt, frames_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
